// File: rtl/sysid_checker.sv
// Boot-time sysid sequencer: reads the ID and timestamp words, compares them
// against build-time values, retries a bounded number of times, reports pass/fail.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID  = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS  = 32'h0000_0000,
  parameter bit          CHECK_TS     = 1'b1,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned RETRIES      = 3,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        av_address,
  output logic        av_read,
  input  logic [31:0] av_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [3:0]  attempts
);

  localparam logic [2:0] LAT = 3'(READ_LATENCY);
  localparam logic [3:0] RET = 4'(RETRIES);

  typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, CHECK, DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        auto_q, auto_d;
  logic        av_address_q, av_address_d;
  logic        av_read_q, av_read_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        id_mis_q, id_mis_d;
  logic        ts_mis_q, ts_mis_d;
  logic [31:0] id_val_q, id_val_d;
  logic [31:0] ts_val_q, ts_val_d;
  logic [3:0]  att_q, att_d;
  logic        entering;

  always_comb begin
    state_d  = state_q;
    auto_d   = auto_q;
    pass_d   = pass_q;
    id_mis_d = id_mis_q;
    ts_mis_d = ts_mis_q;
    id_val_d = id_val_q;
    ts_val_d = ts_val_q;
    att_d    = att_q;

    case (state_q)
      IDLE: begin
        if (start || auto_q) begin
          state_d  = RD_ID;
          auto_d   = 1'b0;
          pass_d   = 1'b0;
          id_mis_d = 1'b0;
          ts_mis_d = 1'b0;
          att_d    = '0;
        end
      end
      RD_ID: begin
        if (cnt_q == LAT) begin
          id_val_d = av_readdata;
          att_d    = att_q + 4'd1;
          state_d  = RD_TS;
        end
      end
      RD_TS: begin
        if (cnt_q == LAT) begin
          ts_val_d = av_readdata;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        id_mis_d = (id_val_q != EXPECTED_ID);
        ts_mis_d = CHECK_TS && (ts_val_q != EXPECTED_TS);
        if ((id_mis_d || ts_mis_d) && (att_q <= RET)) begin
          state_d = RD_ID;
        end else begin
          state_d = DONE;
          pass_d  = !(id_mis_d || ts_mis_d);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus and status outputs are registered, so they are derived from the
    // state being entered rather than the current one.
    entering     = (state_d != state_q);
    cnt_d        = entering ? 3'd0 : cnt_q + 3'd1;
    av_read_d    = entering && ((state_d == RD_ID) || (state_d == RD_TS));
    av_address_d = (state_d == RD_TS);
    busy_d       = (state_d == RD_ID) || (state_d == RD_TS) || (state_d == CHECK);
    done_d       = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      auto_q       <= AUTO_START;
      av_address_q <= 1'b0;
      av_read_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      id_mis_q     <= 1'b0;
      ts_mis_q     <= 1'b0;
      id_val_q     <= '0;
      ts_val_q     <= '0;
      att_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      auto_q       <= auto_d;
      av_address_q <= av_address_d;
      av_read_q    <= av_read_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      id_mis_q     <= id_mis_d;
      ts_mis_q     <= ts_mis_d;
      id_val_q     <= id_val_d;
      ts_val_q     <= ts_val_d;
      att_q        <= att_d;
    end
  end

  assign av_address  = av_address_q;
  assign av_read     = av_read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign id_mismatch = id_mis_q;
  assign ts_mismatch = ts_mis_q;
  assign id_value    = id_val_q;
  assign ts_value    = ts_val_q;
  assign attempts    = att_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Scoreboard bench for sysid_checker: two instances (L=1 with retries/reset,
// L=0 with auto-start and timestamp checking disabled).
module tb_sysid_checker;

  localparam logic [31:0] EXP_ID0 = 32'hC0DE_1D01;
  localparam logic [31:0] EXP_TS0 = 32'h5EED_2024;
  localparam logic [31:0] EXP_ID1 = 32'h0000_ABCD;
  localparam logic [31:0] EXP_TS1 = 32'h1111_2222;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    int          done_cyc;
    logic        pass;
    logic        idm;
    logic        tsm;
    logic [3:0]  att;
    logic [31:0] idv;
    logic [31:0] tsv;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // ---------------- instance 0: L=1, RETRIES=2, CHECK_TS=1, no auto-start
  logic        rst0, start0, addr0, rd0, busy0, done0, pass0, idm0, tsm0;
  logic [31:0] rdata0, idv0, tsv0;
  logic [3:0]  att0;
  logic [31:0] s0_id, s0_ts;
  int          s0_id_reads = 0;
  int          s0_bad_until = 0;

  sysid_checker #(
    .EXPECTED_ID(EXP_ID0), .EXPECTED_TS(EXP_TS0), .CHECK_TS(1'b1),
    .READ_LATENCY(1), .RETRIES(2), .AUTO_START(1'b0)
  ) u0 (
    .clock(clk), .reset(rst0), .start(start0), .av_address(addr0), .av_read(rd0),
    .av_readdata(rdata0), .busy(busy0), .done(done0), .pass(pass0),
    .id_mismatch(idm0), .ts_mismatch(tsm0), .id_value(idv0), .ts_value(tsv0),
    .attempts(att0)
  );

  // One-cycle-latency slave; the first ID reads up to s0_bad_until return junk.
  always @(posedge clk) begin
    if (rd0) begin
      if (addr0 == 1'b0) begin
        rdata0      <= (s0_id_reads < s0_bad_until) ? 32'hDEAD_BEEF : s0_id;
        s0_id_reads <= s0_id_reads + 1;
      end else begin
        rdata0 <= s0_ts;
      end
    end
  end

  // ---------------- instance 1: L=0, RETRIES=3, CHECK_TS=0, auto-start
  logic        rst1, start1, addr1, rd1, busy1, done1, pass1, idm1, tsm1;
  logic [31:0] rdata1, idv1, tsv1;
  logic [3:0]  att1;
  logic [31:0] s1_id, s1_ts;

  sysid_checker #(
    .EXPECTED_ID(EXP_ID1), .EXPECTED_TS(EXP_TS1), .CHECK_TS(1'b0),
    .READ_LATENCY(0), .RETRIES(3), .AUTO_START(1'b1)
  ) u1 (
    .clock(clk), .reset(rst1), .start(start1), .av_address(addr1), .av_read(rd1),
    .av_readdata(rdata1), .busy(busy1), .done(done1), .pass(pass1),
    .id_mismatch(idm1), .ts_mismatch(tsm1), .id_value(idv1), .ts_value(tsv1),
    .attempts(att1)
  );

  assign rdata1 = addr1 ? s1_ts : s1_id;

  // ---------------- monitors
  task automatic chk_res(input string tag, input exp_t e, input int nrd, input logic p,
                         input logic im, input logic tm, input logic [3:0] a,
                         input logic [31:0] iv, input logic [31:0] tv);
    chk({tag, " done_cycle"}, cyc, e.done_cyc);
    chk({tag, " pass"}, 32'(p), 32'(e.pass));
    chk({tag, " id_mismatch"}, 32'(im), 32'(e.idm));
    chk({tag, " ts_mismatch"}, 32'(tm), 32'(e.tsm));
    chk({tag, " attempts"}, 32'(a), 32'(e.att));
    chk({tag, " id_value"}, iv, e.idv);
    chk({tag, " ts_value"}, tv, e.tsv);
    chk({tag, " read_strobes"}, nrd, 2 * int'(e.att));
  endtask

  int nrd0 = 0;
  always @(negedge clk) begin
    if (rst0) nrd0 = 0;
    else begin
      if (rd0) nrd0 = nrd0 + 1;
      if (done0) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL u0 unexpected_done: got done=1 at cycle %0d expected none", cyc);
        end else chk_res("u0", q0.pop_front(), nrd0, pass0, idm0, tsm0, att0, idv0, tsv0);
        nrd0 = 0;
      end
    end
  end

  int nrd1 = 0;
  always @(negedge clk) begin
    if (rst1) nrd1 = 0;
    else begin
      if (rd1) nrd1 = nrd1 + 1;
      if (done1) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL u1 unexpected_done: got done=1 at cycle %0d expected none", cyc);
        end else chk_res("u1", q1.pop_front(), nrd1, pass1, idm1, tsm1, att1, idv1, tsv1);
        nrd1 = 0;
      end
    end
  end

  // ---------------- stimulus
  initial begin
    int c;
    int r;
    rst0 = 1'b1; start0 = 1'b0; s0_id = EXP_ID0; s0_ts = EXP_TS0;
    rst1 = 1'b1; start1 = 1'b0; s1_id = EXP_ID1; s1_ts = 32'h7777_0000;

    fork
      begin : drv0
        repeat (3) @(negedge clk);
        chk("u0 reset busy", 32'(busy0), 0);
        chk("u0 reset av_read", 32'(rd0), 0);
        rst0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("u0 idle_no_autostart busy", 32'(busy0), 0);

        // nominal pass, with a start re-pulse in cycle 2
        @(negedge clk); start0 = 1'b1; c = cyc;
        q0.push_back('{c + 6, 1'b1, 1'b0, 1'b0, 4'd1, EXP_ID0, EXP_TS0});
        @(negedge clk); start0 = 1'b0;
        chk("u0 c1 av_read", 32'(rd0), 1);
        chk("u0 c1 av_address", 32'(addr0), 0);
        chk("u0 c1 busy", 32'(busy0), 1);
        @(negedge clk); start0 = 1'b1;
        chk("u0 c2 av_read", 32'(rd0), 0);
        @(negedge clk); start0 = 1'b0;
        chk("u0 c3 av_read", 32'(rd0), 1);
        chk("u0 c3 av_address", 32'(addr0), 1);
        repeat (2) @(negedge clk);
        chk("u0 c5 busy", 32'(busy0), 1);
        @(negedge clk);
        chk("u0 c6 busy", 32'(busy0), 0);
        repeat (10) @(negedge clk);
        chk("u0 t1 drained", q0.size(), 0);

        // timestamp always wrong: three passes then fail
        s0_ts = 32'hBAD0_0000;
        @(negedge clk); start0 = 1'b1; c = cyc;
        q0.push_back('{c + 16, 1'b0, 1'b0, 1'b1, 4'd3, EXP_ID0, 32'hBAD0_0000});
        @(negedge clk); start0 = 1'b0;
        repeat (20) @(negedge clk);
        chk("u0 t2 drained", q0.size(), 0);
        s0_ts = EXP_TS0;

        // ID wrong on the first pass only
        s0_bad_until = s0_id_reads + 1;
        @(negedge clk); start0 = 1'b1; c = cyc;
        q0.push_back('{c + 11, 1'b1, 1'b0, 1'b0, 4'd2, EXP_ID0, EXP_TS0});
        @(negedge clk); start0 = 1'b0;
        repeat (15) @(negedge clk);
        chk("u0 t3 drained", q0.size(), 0);

        // reset asserted while in RD_TS
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        repeat (2) @(negedge clk);
        rst0 = 1'b1;
        @(negedge clk);
        chk("u0 rst busy", 32'(busy0), 0);
        chk("u0 rst av_read", 32'(rd0), 0);
        chk("u0 rst av_address", 32'(addr0), 0);
        chk("u0 rst done", 32'(done0), 0);
        chk("u0 rst pass", 32'(pass0), 0);
        chk("u0 rst id_mismatch", 32'(idm0), 0);
        chk("u0 rst ts_mismatch", 32'(tsm0), 0);
        chk("u0 rst id_value", idv0, 0);
        chk("u0 rst ts_value", tsv0, 0);
        chk("u0 rst attempts", 32'(att0), 0);
        rst0 = 1'b0;
        repeat (5) @(negedge clk);
        chk("u0 post_rst idle busy", 32'(busy0), 0);
        chk("u0 t4 drained", q0.size(), 0);
      end
      begin : drv1
        repeat (4) @(negedge clk);
        chk("u1 reset attempts", 32'(att1), 0);
        chk("u1 reset id_value", idv1, 0);
        rst1 = 1'b0; r = cyc;
        q1.push_back('{r + 4, 1'b1, 1'b0, 1'b0, 4'd1, EXP_ID1, 32'h7777_0000});
        @(negedge clk);
        chk("u1 auto av_read", 32'(rd1), 1);
        chk("u1 auto av_address", 32'(addr1), 0);
        @(negedge clk);
        chk("u1 ts av_read", 32'(rd1), 1);
        chk("u1 ts av_address", 32'(addr1), 1);
        repeat (8) @(negedge clk);
        chk("u1 t1 drained", q1.size(), 0);

        // ID always wrong: RETRIES=3 gives four passes
        s1_id = 32'h0000_ABCE;
        @(negedge clk); start1 = 1'b1; c = cyc;
        q1.push_back('{c + 13, 1'b0, 1'b1, 1'b0, 4'd4, 32'h0000_ABCE, 32'h7777_0000});
        @(negedge clk); start1 = 1'b0;
        repeat (16) @(negedge clk);
        chk("u1 t2 drained", q1.size(), 0);
      end
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before 100000");
    $fatal(1, "watchdog");
  end

endmodule
